mem_wb_stage: RTL and testbench

- Parametrised MEM/WB pipeline register, successor to the basic register-write-only latch.
- Carries the GPR write, the HI/LO write and the LLbit write from the memory-access stage to write-back.
- Adds stall-vector hold and bubble insertion, flush, a valid bit, and retire/bubble performance counters.
- Sits between the mem stage and the regfile/hilo_reg/LLbit write ports. The ctrl block drives stall and flush.

---
 rtl/mem_wb_stage.sv | 141 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register.
// Carries the GPR, HI/LO and LLbit writes from the memory-access stage to
// write-back. It supports stall hold, bubble insertion, flush and a valid bit,
// and keeps retire/bubble performance counters.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stall[STALL_W]      ctrl stall vector (mem = STAGE_IDX, wb = STAGE_IDX+1)
//   flush               synchronous flush (exception/ERET)
//   cnt_clr             synchronous clear of both counters
//   mem_*               mem-stage payload (valid, GPR, HI/LO, LLbit)
//   wb_*                registered write-back payload
//   retire_cnt          valid instructions entering wb (wraps)
//   bubble_cnt          bubbles/flush slots entering wb (saturates)
module mem_wb_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STAGE_IDX = 4,
  parameter bit          HILO_EN   = 1'b1,
  parameter bit          LLBIT_EN  = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               mem_valid,
  input  logic [ADDR_W-1:0]  mem_wd,
  input  logic               mem_wreg,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_whilo,
  input  logic [DATA_W-1:0]  mem_hi,
  input  logic [DATA_W-1:0]  mem_lo,
  input  logic               mem_llbit_we,
  input  logic               mem_llbit_value,
  output logic               wb_valid,
  output logic [ADDR_W-1:0]  wb_wd,
  output logic               wb_wreg,
  output logic [DATA_W-1:0]  wb_wdata,
  output logic               wb_whilo,
  output logic [DATA_W-1:0]  wb_hi,
  output logic [DATA_W-1:0]  wb_lo,
  output logic               wb_llbit_we,
  output logic               wb_llbit_value,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic ms;
  logic ws;
  logic do_bubble;
  logic do_adv;
  logic retire_inc;
  logic bubble_inc;
  logic unused_stall;

  // Action decode. Flush dominates stall. An advance is taken whenever mem is not stalled.
  always_comb begin
    ms         = stall[STAGE_IDX];
    ws         = stall[STAGE_IDX+1];
    do_bubble  = flush | (ms & ~ws);
    do_adv     = ~flush & ~ms;
    retire_inc = do_adv & mem_valid;
    bubble_inc = do_bubble | (do_adv & ~mem_valid);
  end

  // Only two bits of the stall vector matter here.
  assign unused_stall = ^stall;

  // GPR path and valid bit. Write enables are qualified by mem_valid on advance.
  always_ff @(posedge clk) begin
    if (rst || do_bubble) begin
      wb_valid <= 1'b0;
      wb_wd    <= '0;
      wb_wreg  <= 1'b0;
      wb_wdata <= '0;
    end else if (do_adv) begin
      wb_valid <= mem_valid;
      wb_wd    <= mem_wd;
      wb_wreg  <= mem_wreg & mem_valid;
      wb_wdata <= mem_wdata;
    end
  end

  // HI/LO path, or constant zero with no storage.
  if (HILO_EN) begin : g_hilo
    always_ff @(posedge clk) begin
      if (rst || do_bubble) begin
        wb_whilo <= 1'b0;
        wb_hi    <= '0;
        wb_lo    <= '0;
      end else if (do_adv) begin
        wb_whilo <= mem_whilo & mem_valid;
        wb_hi    <= mem_hi;
        wb_lo    <= mem_lo;
      end
    end
  end else begin : g_no_hilo
    logic unused_hilo;
    assign unused_hilo = ^{mem_whilo, mem_hi, mem_lo};
    assign wb_whilo    = 1'b0;
    assign wb_hi       = '0;
    assign wb_lo       = '0;
  end

  // LLbit path, or constant zero with no storage.
  if (LLBIT_EN) begin : g_llbit
    always_ff @(posedge clk) begin
      if (rst || do_bubble) begin
        wb_llbit_we    <= 1'b0;
        wb_llbit_value <= 1'b0;
      end else if (do_adv) begin
        wb_llbit_we    <= mem_llbit_we & mem_valid;
        wb_llbit_value <= mem_llbit_value;
      end
    end
  end else begin : g_no_llbit
    logic unused_llbit;
    assign unused_llbit   = ^{mem_llbit_we, mem_llbit_value};
    assign wb_llbit_we    = 1'b0;
    assign wb_llbit_value = 1'b0;
  end

  // Performance counters. Retire wraps and bubble saturates. A clear overrides any increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (retire_inc) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (bubble_inc && (bubble_cnt != {CNT_W{1'b1}})) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage.
// dut uses the default parameters. dut_n drops the HI/LO and LLbit paths and
// uses 4-bit counters. Both instances share one stimulus stream.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        cnt_clr;
  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_llbit_we;
  logic        mem_llbit_value;

  logic        wb_valid, wb_wreg, wb_whilo, wb_llbit_we, wb_llbit_value;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata, wb_hi, wb_lo, retire_cnt, bubble_cnt;

  logic        n_valid, n_wreg, n_whilo, n_llbit_we, n_llbit_value;
  logic [4:0]  n_wd;
  logic [31:0] n_wdata, n_hi, n_lo;
  logic [3:0]  n_retire, n_bubble;

  int vectors = 0;
  int errs    = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_llbit_we(mem_llbit_we),
    .mem_llbit_value(mem_llbit_value),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  mem_wb_stage #(.HILO_EN(1'b0), .LLBIT_EN(1'b0), .CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_llbit_we(mem_llbit_we),
    .mem_llbit_value(mem_llbit_value),
    .wb_valid(n_valid), .wb_wd(n_wd), .wb_wreg(n_wreg),
    .wb_wdata(n_wdata), .wb_whilo(n_whilo), .wb_hi(n_hi), .wb_lo(n_lo),
    .wb_llbit_we(n_llbit_we), .wb_llbit_value(n_llbit_value),
    .retire_cnt(n_retire), .bubble_cnt(n_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl must never present "mem running, wb stalled".
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(!stall[4] && stall[5])) else begin
        errs++;
        $error("FAIL illegal_stall observed=%b expected=no ms=0/ws=1", stall);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] wd, input logic wr,
                         input logic [31:0] wdata, input logic whl,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input logic llwe, input logic llv);
    mem_valid = v; mem_wd = wd; mem_wreg = wr; mem_wdata = wdata;
    mem_whilo = whl; mem_hi = hi; mem_lo = lo;
    mem_llbit_we = llwe; mem_llbit_value = llv;
  endtask

  initial begin
    rst = 1'b1; stall = 6'b0; flush = 1'b0; cnt_clr = 1'b0;
    set_mem(1'b1, 5'd3, 1'b1, 32'hAAAA_5555, 1'b1, 32'h1111_2222,
            32'h3333_4444, 1'b1, 1'b1);
    step();
    step();
    // Reset with arbitrary mem payload: everything zero.
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_wd", 64'(wb_wd), 64'd0);
    chk("rst_wreg", 64'(wb_wreg), 64'd0);
    chk("rst_wdata", 64'(wb_wdata), 64'd0);
    chk("rst_hi", 64'(wb_hi), 64'd0);
    chk("rst_llwe", 64'(wb_llbit_we), 64'd0);
    chk("rst_retire", 64'(retire_cnt), 64'd0);
    chk("rst_bubble", 64'(bubble_cnt), 64'd0);
    chk("rst_n_retire", 64'(n_retire), 64'd0);

    // First advance after reset.
    rst = 1'b0;
    set_mem(1'b1, 5'd5, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("adv_valid", 64'(wb_valid), 64'd1);
    chk("adv_wd", 64'(wb_wd), 64'd5);
    chk("adv_wreg", 64'(wb_wreg), 64'd1);
    chk("adv_wdata", 64'(wb_wdata), 64'h1234_5678);
    chk("adv_retire", 64'(retire_cnt), 64'd1);
    chk("adv_bubble", 64'(bubble_cnt), 64'd0);

    // mem stalled, wb proceeds: bubble inserted.
    stall = 6'b011111;
    step();
    chk("bub_wreg", 64'(wb_wreg), 64'd0);
    chk("bub_valid", 64'(wb_valid), 64'd0);
    chk("bub_wd", 64'(wb_wd), 64'd0);
    chk("bub_bubble", 64'(bubble_cnt), 64'd1);
    chk("bub_retire", 64'(retire_cnt), 64'd1);

    // Load a value, then hold it for three cycles against new mem data.
    stall = 6'b000000;
    set_mem(1'b1, 5'd9, 1'b1, 32'hCAFE_0001, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("ld_wd", 64'(wb_wd), 64'd9);
    chk("ld_retire", 64'(retire_cnt), 64'd2);
    stall = 6'b111111;
    set_mem(1'b1, 5'd10, 1'b0, 32'hFFFF_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    step();
    chk("hold_wd", 64'(wb_wd), 64'd9);
    chk("hold_wdata", 64'(wb_wdata), 64'hCAFE_0001);
    chk("hold_wreg", 64'(wb_wreg), 64'd1);
    chk("hold_valid", 64'(wb_valid), 64'd1);
    chk("hold_retire", 64'(retire_cnt), 64'd2);
    chk("hold_bubble", 64'(bubble_cnt), 64'd1);

    // Flush beats a full stall.
    flush = 1'b1;
    step();
    chk("fl_valid", 64'(wb_valid), 64'd0);
    chk("fl_wd", 64'(wb_wd), 64'd0);
    chk("fl_wdata", 64'(wb_wdata), 64'd0);
    chk("fl_bubble", 64'(bubble_cnt), 64'd2);
    chk("fl_retire", 64'(retire_cnt), 64'd2);

    // Invalid advance: enables masked, data still copied, counts as a bubble.
    flush = 1'b0; stall = 6'b000000;
    set_mem(1'b0, 5'd7, 1'b1, 32'h0000_0055, 1'b1, 32'h0000_0011,
            32'h0000_0022, 1'b1, 1'b1);
    step();
    chk("inv_wreg", 64'(wb_wreg), 64'd0);
    chk("inv_whilo", 64'(wb_whilo), 64'd0);
    chk("inv_llwe", 64'(wb_llbit_we), 64'd0);
    chk("inv_wd", 64'(wb_wd), 64'd7);
    chk("inv_wdata", 64'(wb_wdata), 64'h55);
    chk("inv_hi", 64'(wb_hi), 64'h11);
    chk("inv_valid", 64'(wb_valid), 64'd0);
    chk("inv_bubble", 64'(bubble_cnt), 64'd3);
    chk("inv_retire", 64'(retire_cnt), 64'd2);

    // HI/LO and LLbit transfer, and the stripped instance stays zero.
    set_mem(1'b1, 5'd0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001,
            1'b1, 1'b1);
    step();
    chk("hl_whilo", 64'(wb_whilo), 64'd1);
    chk("hl_hi", 64'(wb_hi), 64'hDEAD_BEEF);
    chk("hl_lo", 64'(wb_lo), 64'h1);
    chk("hl_llwe", 64'(wb_llbit_we), 64'd1);
    chk("hl_llv", 64'(wb_llbit_value), 64'd1);
    chk("hl_retire", 64'(retire_cnt), 64'd3);
    chk("n_whilo", 64'(n_whilo), 64'd0);
    chk("n_hi", 64'(n_hi), 64'd0);
    chk("n_lo", 64'(n_lo), 64'd0);
    chk("n_llwe", 64'(n_llbit_we), 64'd0);
    chk("n_llv", 64'(n_llbit_value), 64'd0);
    chk("n_valid", 64'(n_valid), 64'd1);

    // Reset and flush together under stall: reset values.
    rst = 1'b1; flush = 1'b1; stall = 6'b111111;
    step();
    chk("rf_valid", 64'(wb_valid), 64'd0);
    chk("rf_hi", 64'(wb_hi), 64'd0);
    chk("rf_retire", 64'(retire_cnt), 64'd0);
    chk("rf_bubble", 64'(bubble_cnt), 64'd0);

    // Counter edges: 16 valid advances wrap the 4-bit retire counter.
    rst = 1'b0; flush = 1'b0; stall = 6'b000000;
    set_mem(1'b1, 5'd1, 1'b1, 32'h0000_0001, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step();
    chk("n_retire15", 64'(n_retire), 64'hF);
    step();
    chk("n_retire_wrap", 64'(n_retire), 64'd0);
    chk("retire16", 64'(retire_cnt), 64'd16);
    chk("bubble_after_adv", 64'(bubble_cnt), 64'd0);

    // 20 bubbles saturate the 4-bit bubble counter.
    stall = 6'b011111;
    for (int i = 0; i < 20; i++) step();
    chk("n_bubble_sat", 64'(n_bubble), 64'hF);
    chk("bubble20", 64'(bubble_cnt), 64'd20);
    chk("n_retire_keep", 64'(n_retire), 64'd0);

    // Clear wins over a simultaneous increment.
    stall = 6'b000000; cnt_clr = 1'b1;
    set_mem(1'b1, 5'd12, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("clr_retire", 64'(retire_cnt), 64'd0);
    chk("clr_bubble", 64'(bubble_cnt), 64'd0);
    chk("clr_n_retire", 64'(n_retire), 64'd0);
    chk("clr_n_bubble", 64'(n_bubble), 64'd0);
    chk("clr_wd", 64'(wb_wd), 64'd12);
    cnt_clr = 1'b0;
    step();
    chk("post_clr_retire", 64'(retire_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
